key_entry_decoder: RTL
======================

# key_entry_decoder

Receives the active-low push-button and slide-switch inputs of the sale terminal and turns them into barcode entry events. Keys are synchronised, debounced and edge-detected, and digits are assembled into a 4-digit BCD barcode. A single-cycle commit pulse is issued to the terminal core, which performs the lookup and drives the HEX/VGA displays. The block sits between the board pins (KEY, SW) and the SaleTerminal control logic.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required before a key level is accepted. Board builds override this to 250000 (5 ms at 50 MHz). Must be ≥ 1.
- CLOCK_50  in  1  system clock, 50 MHz; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- KEY  in  4  raw push buttons, active-low, asynchronous.
- SW  in  3  raw slide switches, asynchronous. Only SW[0] (commit mode) is used; SW[2:1] are ignored.
- BARCODE  out  16  four BCD digits; the most recent digit is in [3:0].
- DIGIT_COUNT  out  3  digits entered since the last commit or reset, 0..4.
- DIGIT_STROBE  out  1  one-cycle pulse when a digit is accepted.
- BARCODE_VALID  out  1  one-cycle pulse on a successful commit; BARCODE is stable while it is high.
- ENTRY_ERROR  out  1  one-cycle pulse on a rejected event.

## Operation
- **Per key channel.** The channel has:
  - a 2-flop synchroniser (reset value 1);
  - a debounce counter;
  - a debounced level (reset value 1, meaning released).
- **Debounce.** While the synchronised level differs from the debounced level, the counter increments. It is cleared whenever they match. When the count reaches DEBOUNCE_CYCLES, the debounced level takes the synchronised level and the counter clears.
- **Press event.** A press event is a debounced 1→0 transition. Releases generate no events.
- **SW[0].** SW[0] passes through a 2-flop synchroniser (reset value 0). It is sampled in the cycle of the KEY[0] press event.
- **Event decode.** Events are mapped as follows:
  - KEY[3] enters digit 1.
  - KEY[2] enters digit 2.
  - KEY[1] enters digit 3.
  - KEY[0] with SW[0]=0 enters digit 4.
  - KEY[0] with SW[0]=1 is a commit.
- **State machine.** States are EMPTY, ENTRY and FULL.
  - *EMPTY (count 0).* A digit d gives BARCODE←{12'h000,d}, count←1, and the state goes to ENTRY. A commit pulses ENTRY_ERROR and changes nothing else.
  - *ENTRY (count 1..3).* A digit gives BARCODE←{BARCODE[11:0],d} and count+1. At count 4 the state goes to FULL. A commit pulses ENTRY_ERROR; the digits and count are kept.
  - *FULL (count 4).* A digit pulses ENTRY_ERROR and BARCODE is unchanged. A commit pulses BARCODE_VALID, count←0, and the state goes to EMPTY. BARCODE holds its value until the next digit.
- **Strobes.** DIGIT_STROBE pulses for every accepted digit.
- **Simultaneous events.** If two or more press events occur in the same cycle, all are discarded and ENTRY_ERROR pulses once.
- **Exclusivity.** At most one of DIGIT_STROBE, BARCODE_VALID and ENTRY_ERROR is high in any cycle.

## Timing
- **Reset values.** All outputs are 0 after reset: BARCODE=16'h0000, DIGIT_COUNT=0, all pulses low, state EMPTY.
- **Reset mid-operation.** RESET clears the state, count, barcode and debounce counters within one edge. A key still held at reset release becomes a press event after debounce, because the debounced level resets to released.
- **Latency.** A clean KEY falling edge gives a press-decoded output (DIGIT_STROBE, BARCODE_VALID or ENTRY_ERROR) DEBOUNCE_CYCLES+3 rising edges later: 2 synchroniser edges, DEBOUNCE_CYCLES debounce edges, and 1 registered output. BARCODE and DIGIT_COUNT update on the same edge as the pulse.
- **Pulse width.** All pulses are exactly 1 cycle, regardless of how long the key is held.
- **Glitch rejection.** A low glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no event.
- **Counter width.** The debounce counter is $clog2(DEBOUNCE_CYCLES+1) bits wide and never wraps.
- **SW[0] setup.** SW[0] must be stable for at least 2 cycles before the KEY[0] press event is decoded.

## Test plan
- **Digit entry and commit.** With DEBOUNCE_CYCLES=4, press KEY[3], KEY[2], KEY[3], KEY[1], each low for 10 cycles with 20-cycle gaps. Then set SW[0]=1 and press KEY[0]. Required response:
  - four DIGIT_STROBE pulses;
  - DIGIT_COUNT goes 1,2,3,4;
  - BARCODE=16'h1213;
  - one BARCODE_VALID pulse, after which DIGIT_COUNT=0 and BARCODE stays 16'h1213.
- **Glitch rejection.** Drive KEY[2] low for 3 cycles. Required: no pulse, and BARCODE/DIGIT_COUNT unchanged. Then drive it low for 6 cycles: DIGIT_STROBE pulses exactly DEBOUNCE_CYCLES+3 edges after the falling edge.
- **Early commit.** Enter 3,4 (KEY[1], then KEY[0] with SW[0]=0), then commit. Required: ENTRY_ERROR pulses, no BARCODE_VALID, DIGIT_COUNT stays 2, BARCODE=16'h0034.
- **Overflow.** Enter 1,1,1,1, then press KEY[2]. Required: ENTRY_ERROR pulses, and BARCODE stays 16'h1111 with DIGIT_COUNT 4.
- **Simultaneous press.** Press KEY[3] and KEY[1] in the same cycle. Required: a single ENTRY_ERROR pulse and no DIGIT_STROBE.
- **Reset mid-entry.** After 2 digits, assert RESET for 1 cycle. Required: all outputs 0, and the next digit 2 gives BARCODE=16'h0002, DIGIT_COUNT=1.

Source files
------------

// File: rtl/key_entry_decoder.sv
// key_entry_decoder
// Turns the active-low board push buttons (KEY) and the commit-mode switch
// (SW[0]) into barcode entry events: each key is synchronised, debounced and
// falling-edge detected, and the resulting press events drive a small FSM
// that assembles a 4-digit BCD barcode and issues a one-cycle commit pulse.
//
// state | meaning
// ------+-------------------------------------------------
// EMPTY | no digits held since the last commit or reset
// ENTRY | 1..3 digits held, more digits accepted
// FULL  | 4 digits held, only a commit is accepted

module key_entry_decoder #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic [3:0]  KEY,
  input  logic [2:0]  SW,
  output logic [15:0] BARCODE,
  output logic [2:0]  DIGIT_COUNT,
  output logic        DIGIT_STROBE,
  output logic        BARCODE_VALID,
  output logic        ENTRY_ERROR
);

  // Counter is sized to hold DEBOUNCE_CYCLES; it clears on the edge where the
  // DEBOUNCE_CYCLES-th differing sample is seen, so it never wraps.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ENTRY = 2'd1,
    FULL  = 2'd2
  } state_t;

  logic [3:0] key_s1;
  logic [3:0] key_s2;
  logic [3:0] key_deb;
  logic [3:0] key_deb_d;
  logic [3:0] press;
  logic       sw_s1;
  logic       sw_s2;

  // SW[2:1] have no function in this block.
  logic unused_sw;
  assign unused_sw = ^SW[2:1];

  // Two-flop synchronisers; keys reset to released (1), commit mode to off.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      key_s1 <= 4'hF;
      key_s2 <= 4'hF;
      sw_s1  <= 1'b0;
      sw_s2  <= 1'b0;
    end else begin
      key_s1 <= KEY;
      key_s2 <= key_s1;
      sw_s1  <= SW[0];
      sw_s2  <= sw_s1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_deb
    logic             deb_q;
    logic [CNT_W-1:0] cnt_q;

    // Accept the synchronised level once it has differed from the debounced
    // level for DEBOUNCE_CYCLES consecutive samples; any agreement restarts.
    always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
        deb_q <= 1'b1;
        cnt_q <= '0;
      end else if (key_s2[g] == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        deb_q <= key_s2[g];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign key_deb[g] = deb_q;
  end

  // Delayed copy of the debounced levels for falling-edge detection.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      key_deb_d <= 4'hF;
    end else begin
      key_deb_d <= key_deb;
    end
  end

  // Press = debounced 1->0; releases are not events.
  assign press = key_deb_d & ~key_deb;

  logic       multi_press;
  logic       is_digit;
  logic       is_commit;
  logic [3:0] digit;

  // Event decode: KEY[3..1] are digits 1..3, KEY[0] is digit 4 or commit.
  always_comb begin
    multi_press = 1'b0;
    is_digit    = 1'b0;
    is_commit   = 1'b0;
    digit       = 4'd0;
    case (press)
      4'b0000: ;
      4'b1000: begin is_digit = 1'b1; digit = 4'd1; end
      4'b0100: begin is_digit = 1'b1; digit = 4'd2; end
      4'b0010: begin is_digit = 1'b1; digit = 4'd3; end
      4'b0001: begin
        if (sw_s2) begin
          is_commit = 1'b1;
        end else begin
          is_digit = 1'b1;
          digit    = 4'd4;
        end
      end
      default: multi_press = 1'b1;
    endcase
  end

  state_t      state_q, state_n;
  logic [15:0] barcode_q, barcode_n;
  logic [2:0]  count_q, count_n;
  logic        strobe_q, strobe_n;
  logic        valid_q, valid_n;
  logic        error_q, error_n;

  // FSM state and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q   <= EMPTY;
      barcode_q <= 16'h0000;
      count_q   <= 3'd0;
      strobe_q  <= 1'b0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_n;
      barcode_q <= barcode_n;
      count_q   <= count_n;
      strobe_q  <= strobe_n;
      valid_q   <= valid_n;
      error_q   <= error_n;
    end
  end

  // Next-state and output decode; each branch raises at most one pulse.
  always_comb begin
    state_n   = state_q;
    barcode_n = barcode_q;
    count_n   = count_q;
    strobe_n  = 1'b0;
    valid_n   = 1'b0;
    error_n   = 1'b0;
    if (multi_press) begin
      error_n = 1'b1;
    end else if (is_digit) begin
      case (state_q)
        EMPTY: begin
          barcode_n = {12'h000, digit};
          count_n   = 3'd1;
          strobe_n  = 1'b1;
          state_n   = ENTRY;
        end
        ENTRY: begin
          barcode_n = {barcode_q[11:0], digit};
          count_n   = count_q + 3'd1;
          strobe_n  = 1'b1;
          if (count_q == 3'd3) begin
            state_n = FULL;
          end
        end
        default: begin
          error_n = 1'b1;
        end
      endcase
    end else if (is_commit) begin
      if (state_q == FULL) begin
        valid_n = 1'b1;
        count_n = 3'd0;
        state_n = EMPTY;
      end else begin
        error_n = 1'b1;
      end
    end
  end

  assign BARCODE       = barcode_q;
  assign DIGIT_COUNT   = count_q;
  assign DIGIT_STROBE  = strobe_q;
  assign BARCODE_VALID = valid_q;
  assign ENTRY_ERROR   = error_q;

endmodule
